// File: rtl/ram_arbiter_if.sv
// Valid/ready memory transaction bundle shared by the arbiter's request ports.
// The master drives the request and the slave returns the ready pulse and read data.
interface ram_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output addr,
        output wstrb,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wstrb,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port synchronous RAM (IDLE/ISSUE/DONE).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module ram_arbiter #(
    parameter int WORDS = 256
) (
    input  logic               clk,
    input  logic               reset,
    ram_arbiter_if.slave       m0,
    ram_arbiter_if.slave       m1,
    output logic [3:0]         ram_wen,
    output logic [21:0]        ram_addr,
    output logic [31:0]        ram_wdata,
    input  logic [31:0]        ram_rdata,
    output logic               busy,
    output logic               grant
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    localparam logic [22:0] WORDS_W = 23'(WORDS);

    state_t      state;
    logic        rdy0;
    logic        rdy1;
    logic        oor;

    logic        pick1;
    logic [31:0] sel_addr;
    logic [3:0]  sel_wstrb;
    logic [31:0] sel_wdata;
    logic        sel_oor;
    logic        unused_addr_lsbs;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Port last granted; reset to 1 so port 0 wins the first tie.
    logic last;

    always_comb begin
        pick1 = m1.valid & (~m0.valid | ~last);
    end
`else
    always_comb begin
        pick1 = m1.valid & ~m0.valid;
    end
`endif

    always_comb begin
        sel_addr  = pick1 ? m1.addr  : m0.addr;
        sel_wstrb = pick1 ? m1.wstrb : m0.wstrb;
        sel_wdata = pick1 ? m1.wdata : m0.wdata;
        sel_oor   = (sel_addr[31:24] != 8'd0) ||
                    ({1'b0, sel_addr[23:2]} >= WORDS_W);
    end

    assign unused_addr_lsbs = ^sel_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
            oor       <= 1'b0;
            busy      <= 1'b0;
            grant     <= 1'b0;
            ram_wen   <= 4'd0;
            ram_addr  <= 22'd0;
            ram_wdata <= 32'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last      <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0.valid || m1.valid) begin
                        grant     <= pick1;
                        ram_addr  <= sel_addr[23:2];
                        ram_wdata <= sel_wdata;
                        // Out-of-range writes never reach the RAM.
                        ram_wen   <= sel_oor ? 4'd0 : sel_wstrb;
                        oor       <= sel_oor;
                        busy      <= 1'b1;
                        state     <= ISSUE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        last      <= pick1;
`endif
                    end
                end
                ISSUE: begin
                    ram_wen <= 4'd0;
                    rdy0    <= ~grant;
                    rdy1    <= grant;
                    state   <= DONE;
                end
                DONE: begin
                    rdy0  <= 1'b0;
                    rdy1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM output is only meaningful during the ready cycle.
    assign m0.ready = rdy0;
    assign m1.ready = rdy1;
    assign m0.rdata = (rdy0 && !oor) ? ram_rdata : 32'd0;
    assign m1.rdata = (rdy1 && !oor) ? ram_rdata : 32'd0;

endmodule
